// File: rtl/apb4_pkg.sv
// Shared APB4 definitions: FSM state encoding and PPROT bit constants.
package apb4_pkg;

  typedef enum logic [1:0] {
    APB4_IDLE   = 2'd0,
    APB4_SETUP  = 2'd1,
    APB4_ACCESS = 2'd2,
    APB4_RESP   = 2'd3
  } apb4_state_e;

  localparam logic [2:0] APB4_PROT_PRIV   = 3'b001;
  localparam logic [2:0] APB4_PROT_NONSEC = 3'b010;
  localparam logic [2:0] APB4_PROT_INSTR  = 3'b100;

endpackage

// File: rtl/apb4_if.sv
// APB4 bus bundle with master and slave views.
interface apb4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [2:0]              pprot;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb4_master_bridge.sv
// Single-outstanding valid/ready to APB4 master bridge with an ACCESS-phase
// stall timeout. All bus and response outputs come straight from registers.
module apb4_master_bridge
  import apb4_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        pclk,
  input  logic                        presetn,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [APB_ADDR_WIDTH-1:0]   req_addr,
  input  logic                        req_write,
  input  logic [APB_DATA_WIDTH-1:0]   req_wdata,
  input  logic [APB_DATA_WIDTH/8-1:0] req_strb,
  input  logic [2:0]                  req_prot,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [APB_DATA_WIDTH-1:0]   rsp_rdata,
  output logic                        rsp_err,
  output logic                        rsp_timeout,
  apb4_if.master                      apb
);

  localparam int STRB_W = APB_DATA_WIDTH / 8;
  // A zero-cycle timeout still needs a 1-bit counter to keep the code legal.
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN  = (TIMEOUT_CYCLES > 0);
  // Counter value seen on the last allowed stalled ACCESS cycle.
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  localparam logic [1:0] ST_IDLE   = APB4_IDLE;
  localparam logic [1:0] ST_SETUP  = APB4_SETUP;
  localparam logic [1:0] ST_ACCESS = APB4_ACCESS;
  localparam logic [1:0] ST_RESP   = APB4_RESP;

  logic [1:0]                state_r;
  logic [APB_ADDR_WIDTH-1:0] paddr_r;
  logic                      pwrite_r;
  logic [APB_DATA_WIDTH-1:0] pwdata_r;
  logic [STRB_W-1:0]         pstrb_r;
  logic [2:0]                pprot_r;
  logic                      psel_r;
  logic                      penable_r;
  logic [CNT_W-1:0]          cnt_r;
  logic                      rsp_valid_r;
  logic                      rsp_err_r;
  logic                      rsp_timeout_r;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_r;
  logic                      timeout_hit_s;

  assign req_ready   = (state_r == ST_IDLE);
  assign rsp_valid   = rsp_valid_r;
  assign rsp_err     = rsp_err_r;
  assign rsp_timeout = rsp_timeout_r;
  assign rsp_rdata   = rsp_rdata_r;

  assign apb.paddr   = paddr_r;
  assign apb.pwrite  = pwrite_r;
  assign apb.pwdata  = pwdata_r;
  assign apb.pstrb   = pstrb_r;
  assign apb.pprot   = pprot_r;
  assign apb.psel    = psel_r;
  assign apb.penable = penable_r;

  // Detect the final stalled ACCESS cycle before the transfer is abandoned.
  always_comb begin
    timeout_hit_s = 1'b0;
    if (TO_EN) begin
      timeout_hit_s = (cnt_r == TO_LAST);
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // FSM, captured request fields, timeout counter and response registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_r       <= ST_IDLE;
      paddr_r       <= '0;
      pwrite_r      <= 1'b0;
      pwdata_r      <= '0;
      pstrb_r       <= '0;
      pprot_r       <= 3'b000;
      psel_r        <= 1'b0;
      penable_r     <= 1'b0;
      cnt_r         <= '0;
      rsp_valid_r   <= 1'b0;
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
      rsp_rdata_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            paddr_r   <= req_addr;
            pwrite_r  <= req_write;
            pprot_r   <= req_prot;
            // Reads never present stale write data or strobes on the bus.
            pwdata_r  <= req_write ? req_wdata : '0;
            pstrb_r   <= req_write ? req_strb  : '0;
            psel_r    <= 1'b1;
            penable_r <= 1'b0;
            cnt_r     <= '0;
            state_r   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_r <= 1'b1;
          state_r   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // pready takes priority over a coincident timeout.
          if (apb.pready) begin
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            rsp_valid_r   <= 1'b1;
            rsp_err_r     <= apb.pslverr;
            rsp_timeout_r <= 1'b0;
            rsp_rdata_r   <= pwrite_r ? '0 : apb.prdata;
            state_r       <= ST_RESP;
          end else if (timeout_hit_s) begin
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            rsp_valid_r   <= 1'b1;
            rsp_err_r     <= 1'b1;
            rsp_timeout_r <= 1'b1;
            rsp_rdata_r   <= '0;
            state_r       <= ST_RESP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          psel_r      <= 1'b0;
          penable_r   <= 1'b0;
          rsp_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Self-checking bench for apb4_master_bridge: directed test-plan steps followed
// by randomized transfers, each checked cycle by cycle against a timing model.
module tb_apb4_master_bridge;
  import apb4_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic        pclk;
  logic        presetn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  int checks = 0;
  int errors = 0;

  apb4_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

  apb4_master_bridge #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .req_strb    (req_strb),
    .req_prot    (req_prot),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .apb         (apb)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic sel, input logic en,
                         input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] prot);
    chk({tag, "_psel"},    apb.psel,    sel);
    chk({tag, "_penable"}, apb.penable, en);
    chk({tag, "_paddr"},   apb.paddr,   addr);
    chk({tag, "_pwrite"},  apb.pwrite,  wr);
    chk({tag, "_pwdata"},  apb.pwdata,  wd);
    chk({tag, "_pstrb"},   apb.pstrb,   st);
    chk({tag, "_pprot"},   apb.pprot,   prot);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_bus(tag, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 3'b000);
    chk({tag, "_rsp_valid"},   rsp_valid,   1'b0);
    chk({tag, "_rsp_err"},     rsp_err,     1'b0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 1'b0);
    chk({tag, "_rsp_rdata"},   rsp_rdata,   32'h0);
    chk({tag, "_req_ready"},   req_ready,   1'b1);
  endtask

  // Runs one transfer starting in an IDLE cycle (posedge+1). waits = number of
  // pready-low ACCESS cycles before the slave answers; bp = response stall cycles.
  task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [2:0] prot, input int waits, input logic slverr,
                         input logic [31:0] rdata, input int bp);
    logic        to_exp;
    int          last_acc;
    logic [31:0] e_wd;
    logic [3:0]  e_st;
    logic        e_err;
    logic [31:0] e_rd;
    // Reference model of the expected outcome.
    to_exp   = (TO != 0) && (waits >= TO);
    last_acc = to_exp ? (2 + TO - 1) : (2 + waits);
    e_wd     = wr ? wdata : 32'h0;
    e_st     = wr ? strb  : 4'h0;
    e_err    = to_exp ? 1'b1 : slverr;
    e_rd     = (to_exp || wr) ? 32'h0 : rdata;

    // Cycle 0: offer the request.
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_wdata = wdata; req_strb = strb; req_prot = prot;
    chk({tag, "_accept_ready"}, req_ready, 1'b1);
    @(posedge pclk); #1;

    // Cycle 1: SETUP; scramble request inputs and tease with ignored pready.
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_strb = 4'($urandom); req_prot = 3'($urandom); req_write = 1'($urandom);
    apb.pready = 1'($urandom); apb.pslverr = 1'($urandom); apb.prdata = $urandom;
    chk_bus({tag, "_setup"}, 1'b1, 1'b0, addr, wr, e_wd, e_st, prot);
    chk({tag, "_setup_req_ready"}, req_ready, 1'b0);
    chk({tag, "_setup_rsp_valid"}, rsp_valid, 1'b0);

    // ACCESS cycles.
    for (int c = 2; c <= last_acc; c++) begin
      @(posedge pclk); #1;
      if (c == 2 + waits) begin
        apb.pready = 1'b1; apb.pslverr = slverr; apb.prdata = rdata;
      end else begin
        apb.pready = 1'b0; apb.pslverr = 1'($urandom); apb.prdata = $urandom;
      end
      chk_bus({tag, "_access"}, 1'b1, 1'b1, addr, wr, e_wd, e_st, prot);
      chk({tag, "_access_rsp_valid"}, rsp_valid, 1'b0);
      chk({tag, "_access_req_ready"}, req_ready, 1'b0);
    end

    // RESP with optional backpressure; a competing request is presented.
    rsp_ready = 1'b0;
    @(posedge pclk); #1;
    for (int b = 0; b <= bp; b++) begin
      apb.pready = 1'($urandom); apb.pslverr = 1'($urandom); apb.prdata = $urandom;
      req_valid = 1'b1; req_addr = $urandom; req_write = 1'($urandom);
      chk({tag, "_rsp_valid"},   rsp_valid,   1'b1);
      chk({tag, "_rsp_err"},     rsp_err,     e_err);
      chk({tag, "_rsp_timeout"}, rsp_timeout, to_exp);
      chk({tag, "_rsp_rdata"},   rsp_rdata,   e_rd);
      chk({tag, "_rsp_req_ready"}, req_ready, 1'b0);
      chk({tag, "_rsp_psel"},    apb.psel,    1'b0);
      chk({tag, "_rsp_penable"}, apb.penable, 1'b0);
      rsp_ready = (b == bp);
      @(posedge pclk); #1;
    end

    // Back in IDLE.
    rsp_ready = 1'b0; req_valid = 1'b0; apb.pready = 1'b0; apb.pslverr = 1'b0;
    chk({tag, "_idle_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_idle_req_ready"}, req_ready, 1'b1);
    chk({tag, "_idle_paddr_hold"}, apb.paddr, addr);
    chk({tag, "_idle_pwrite_hold"}, apb.pwrite, wr);
  endtask

  initial begin
    presetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_strb = 4'h0; req_prot = 3'b000; rsp_ready = 1'b0;
    apb.pready = 1'b0; apb.prdata = 32'h0; apb.pslverr = 1'b0;

    repeat (2) @(posedge pclk);
    #1;
    chk_reset_vals("reset");
    @(negedge pclk); presetn = 1'b1;
    @(posedge pclk); #1;

    // Zero-wait write.
    run_txn("wr0", 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 1'b0, 32'h0, 0);
    // Read with 3 wait states (pready on the 4th ACCESS cycle, also the timeout edge).
    run_txn("rd3", 1'b0, 32'h2000_0010, 32'hA5A5_5A5A, 4'hF, APB4_PROT_PRIV, 3, 1'b0,
            32'h1234_5678, 0);
    // Slave error on a write.
    run_txn("slverr", 1'b1, 32'h3000_0000, 32'h0000_00FF, 4'h1, APB4_PROT_NONSEC, 1, 1'b1,
            32'h0, 0);
    // Timeout with pready held low.
    run_txn("tmo", 1'b0, 32'h4000_0008, 32'h0, 4'h0, APB4_PROT_INSTR, 20, 1'b0,
            32'hFFFF_FFFF, 0);
    // Backpressure on the response, then an immediate follow-on request.
    run_txn("bp", 1'b0, 32'h5000_0020, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'hCAFE_F00D, 5);
    run_txn("after_bp", 1'b1, 32'h5000_0024, 32'h0BAD_F00D, 4'h6, 3'b011, 2, 1'b0, 32'h0, 0);

    // Reset mid-transfer during ACCESS.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h6000_0000;
    req_wdata = 32'h1111_2222; req_strb = 4'hF; req_prot = 3'b111;
    @(posedge pclk); #1;
    req_valid = 1'b0;
    @(posedge pclk); #1;
    apb.pready = 1'b0;
    chk("midrst_in_access", apb.penable, 1'b1);
    #2 presetn = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (2) @(posedge pclk);
    #1;
    chk("midrst_hold_rsp_valid", rsp_valid, 1'b0);
    @(negedge pclk); presetn = 1'b1;
    @(posedge pclk); #1;
    run_txn("post_rst", 1'b0, 32'h7000_0004, 32'h0, 4'h0, 3'b001, 1, 1'b0, 32'h8765_4321, 1);

    // Randomized transfers.
    for (int i = 0; i < 20; i++) begin
      run_txn("rand", 1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
              int'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0), $urandom,
              int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb4_master_bridge.md
# apb4_master_bridge

Single-outstanding bridge from a valid/ready request/response channel onto an APB4 master port. It sits directly upstream of APB4 slaves, driving the `master` modport of the team's `apb4_if`. It sequences the SETUP and ACCESS phases, honours `pready` wait states, returns read data and `pslverr`, and aborts transfers that stall beyond a programmable timeout.

## Interface
- `APB_ADDR_WIDTH`, 32: address width; must match the connected `apb4_if`.
- `APB_DATA_WIDTH`, 32: data width (8/16/32); must match the connected `apb4_if`.
- `TIMEOUT_CYCLES`, 256: maximum ACCESS cycles before abort; 0 disables the timeout.
- One clock; reset is asynchronous and active-low (ports `pclk`, `presetn`).
- `pclk`  in  1  clock.
- `presetn`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  bridge can accept a request.
- `req_addr`  in  APB_ADDR_WIDTH  target address.
- `req_write`  in  1  1 = write, 0 = read.
- `req_wdata`  in  APB_DATA_WIDTH  write data.
- `req_strb`  in  APB_DATA_WIDTH/8  write byte strobes.
- `req_prot`  in  3  protection attributes.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  APB_DATA_WIDTH  read data; 0 for writes.
- `rsp_err`  out  1  `pslverr` was sampled high, or the transfer timed out.
- `rsp_timeout`  out  1  the transfer was aborted by the timeout.
- `apb`  modport  `apb4_if.master`  APB4 bus.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - `req_ready`=1 (decoded from state).
  - On `req_valid`, register addr, write, prot, wdata and strb, then go to SETUP.
  - For a read, the registered `pwdata` and `pstrb` are forced to 0.
- SETUP: `psel`=1, `penable`=0; always advances to ACCESS after one cycle.
- ACCESS: `psel`=1, `penable`=1.
  - `pready`=1: capture `prdata` (reads only) and `pslverr`, then go to RESP.
  - `pready`=0: stay in ACCESS and increment the timeout counter.
- Timeout:
  - Fires when ACCESS has lasted `TIMEOUT_CYCLES` cycles with `pready` low in every one of them.
  - Drops `psel`/`penable` and goes to RESP with `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - This deliberately abandons the APB transfer.
- RESP: `rsp_valid`=1 with all response fields held stable; on `rsp_ready`, go to IDLE.
- `paddr`, `pwrite`, `pwdata`, `pstrb` and `pprot` hold their values from SETUP through the end of ACCESS, and also while idle.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`; it clears on entry to SETUP. With `TIMEOUT_CYCLES`=0 the counter is not compared.
- Reset values (asynchronous, also mid-transfer):
  - State = IDLE.
  - `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `pstrb`, `pprot` = 0.
  - `rsp_valid`, `rsp_err`, `rsp_timeout`, `rsp_rdata` = 0.
  - `req_ready`=1.
  - An in-flight transfer is lost and no response is issued.

## Timing
- Request accepted at cycle 0. SETUP is cycle 1. ACCESS is cycle 2 or later.
- `rsp_valid` rises the cycle after the `pready` sample: at minimum cycle 3.
- Each wait state adds 1 cycle.
- Throughput is at most one transfer per 4 cycles, because RESP→IDLE costs a cycle.
- `req_ready` is low from SETUP until the return to IDLE, so no request is accepted while a response is pending.
- `rsp_valid` is never deasserted without `rsp_ready`.
- `pready` is sampled only in ACCESS; `pready` or `pslverr` high in other states is ignored.
- If timeout and `pready` coincide in the same cycle, `pready` wins: normal completion, `rsp_timeout`=0.

## Structure
- Shared package `apb4_pkg`:
  - `apb4_state_e` (IDLE/SETUP/ACCESS/RESP).
  - `APB4_PROT_*` constants for privileged, non-secure and instruction bits.
- No sub-module: the FSM, the request/response registers and the timeout counter stay inline.

## Test plan
- Zero-wait write:
  - Stimulus: addr 0x1000_0004, wdata 0xDEAD_BEEF, strb 0xF, prot 3'b010.
  - Required: `psel` cycle 1, `penable` cycle 2, `rsp_valid` cycle 3, `rsp_err`=0, `rsp_rdata`=0; bus fields stable across cycles 1-2.
- Read with 3 wait states:
  - Stimulus: slave returns 0x1234_5678 with `pready` high on the 4th ACCESS cycle.
  - Required: `rsp_valid` at cycle 6, `rsp_rdata`=0x1234_5678, `pwdata`/`pstrb`=0 throughout.
- Slave error: `pslverr`=1 together with `pready` on a write -> `rsp_err`=1, `rsp_timeout`=0.
- Timeout, `TIMEOUT_CYCLES`=4:
  - Stimulus: `pready` held low.
  - Required: `psel` drops after 4 ACCESS cycles, then `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0. A variant with `pready` high on the 4th ACCESS cycle completes normally.
- Backpressure: `rsp_ready` held low for 5 cycles -> `rsp_valid` and its data stay stable and `req_ready` stays 0 despite `req_valid`=1; the next request is accepted the cycle after returning to IDLE.
- Reset mid-transfer: `presetn` asserted during ACCESS -> all outputs at reset values immediately, no response issued; the first request after release completes normally.
